// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback-port arbiter and its result queue.
package wb_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_JUMP   = 7'b1101111;

  typedef enum logic {
    IDLE,
    LD_WAIT
  } state_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous in-order FIFO holding displaced {rd, data} ALU results; flushed by rst.
module wb_fifo #(
  parameter  int W     = 37,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count,
  output logic [W-1:0] head
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // NOTE: storage is deliberately not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: load returns win the register-file write port, ALU results queue behind.
// Optional build macro WB_PERF_EN adds the perf_conflicts counter output.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int QDEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              ld_issue,
  input  logic [REG_AW-1:0] ld_rd,
  input  logic              done,
  input  logic [XLEN-1:0]   dcache_out,
  output logic              wb_enable,
  output logic [REG_AW-1:0] wb_rd_addr,
  output logic [XLEN-1:0]   wb_rd_data,
  output logic              stall
`ifdef WB_PERF_EN
  ,
  output logic [31:0]       perf_conflicts
`endif
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int EW = REG_AW + XLEN;

  state_t            state, state_nx;
  logic [REG_AW-1:0] ld_rd_q, ld_rd_nx;

  logic          ld_sel, ld_accept, alu_accept, alu_direct;
  logic          q_push, q_pop, q_full, q_empty;
  logic [CW-1:0] q_count;
  logic [EW-1:0] q_head;

  logic              sel_upd, sel_en;
  logic [REG_AW-1:0] sel_rd;
  logic [XLEN-1:0]   sel_data;

  wb_fifo #(.W(EW), .DEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .din   ({alu_rd, alu_data}),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count),
    .head  (q_head)
  );

  assign ld_sel     = (state == LD_WAIT) && done;
  assign ld_accept  = ld_issue && ((state == IDLE) || ld_sel);
  assign alu_accept = alu_valid && !q_full;
  assign stall      = (q_count == CW'(QDEPTH)) || ((state == LD_WAIT) && ld_issue && !done);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sel_upd    = 1'b0;
    sel_en     = 1'b0;
    sel_rd     = '0;
    sel_data   = '0;
    q_pop      = 1'b0;
    alu_direct = 1'b0;
    if (ld_sel) begin
      sel_upd  = 1'b1;
      sel_en   = |ld_rd_q;
      sel_rd   = ld_rd_q;
      sel_data = dcache_out;
    end else if (!q_empty) begin
      sel_upd            = 1'b1;
      sel_en             = 1'b1;
      {sel_rd, sel_data} = q_head;
      q_pop              = 1'b1;
    end else if (alu_accept) begin
      sel_upd    = 1'b1;
      sel_en     = |alu_rd;
      sel_rd     = alu_rd;
      sel_data   = alu_data;
      alu_direct = 1'b1;
    end
  end

  // rd==0 results are swallowed here, so the queue only ever holds real writes.
  assign q_push = alu_accept && !alu_direct && (|alu_rd);

  always_comb begin
    state_nx = state;
    ld_rd_nx = ld_rd_q;
    if (ld_accept) begin
      state_nx = LD_WAIT;
      ld_rd_nx = ld_rd;
    end else if (ld_sel) begin
      state_nx = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ld_rd_q    <= '0;
      wb_enable  <= 1'b0;
      wb_rd_addr <= '0;
      wb_rd_data <= '0;
    end else begin
      state     <= state_nx;
      ld_rd_q   <= ld_rd_nx;
      wb_enable <= sel_en;
      if (sel_upd) begin
        wb_rd_addr <= sel_rd;
        wb_rd_data <= sel_data;
      end
    end
  end

`ifdef WB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst)                                 perf_conflicts <= '0;
    else if (q_push && (perf_conflicts != '1)) perf_conflicts <= perf_conflicts + 1'b1;
  end
`endif

  a_no_alu_when_full: assert property (@(posedge clk) disable iff (rst) !(alu_valid && q_full));

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed spec scenarios plus randomized traffic vs a queue model.
module tb_wb_port_arbiter;

  localparam int QDEPTH = 2;
  typedef logic [36:0] ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, ld_issue, done;
  logic [4:0]  alu_rd, ld_rd;
  logic [31:0] alu_data, dcache_out;
  logic        wb_enable, stall;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_data;
`ifdef WB_PERF_EN
  logic [31:0] perf_conflicts;
`endif

  int total = 0;
  int bad   = 0;

  ent_t        exp_q[$];
  ent_t        aq[$];
  bit          pend;
  logic [4:0]  prd;
  bit          last_acc;
  int unsigned conflicts;

  wb_port_arbiter #(.XLEN(32), .REG_AW(5), .QDEPTH(QDEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .ld_issue   (ld_issue),
    .ld_rd      (ld_rd),
    .done       (done),
    .dcache_out (dcache_out),
    .wb_enable  (wb_enable),
    .wb_rd_addr (wb_rd_addr),
    .wb_rd_data (wb_rd_data),
    .stall      (stall)
`ifdef WB_PERF_EN
    ,
    .perf_conflicts (perf_conflicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock of stimulus: drive inputs, check stall, advance the reference model, wait the edge.
  task automatic cycle(input bit av, input logic [4:0] ard, input logic [31:0] adat,
                       input bit li, input logic [4:0] lrd, input bit dn, input logic [31:0] dout);
    bit ld_done, direct;
    int qn;
    alu_valid = av;  alu_rd = ard;  alu_data = adat;
    ld_issue  = li;  ld_rd  = lrd;
    done      = dn;  dcache_out = dout;
    #1;
    qn = aq.size();
    check("stall", stall, (qn == QDEPTH) || (pend && li && !dn));
    ld_done = pend && dn;
    direct  = 1'b0;
    if (ld_done) begin
      if (prd != 0) exp_q.push_back({prd, dout});
    end else if (qn > 0) begin
      exp_q.push_back(aq.pop_front());
    end else if (av) begin
      direct = 1'b1;
      if (ard != 0) exp_q.push_back({ard, adat});
    end
    if (av && (qn < QDEPTH) && !direct && (ard != 0)) begin
      aq.push_back({ard, adat});
      conflicts++;
    end
    last_acc = li && (!pend || ld_done);
    if (last_acc) begin
      pend = 1'b1;
      prd  = lrd;
    end else if (ld_done) begin
      pend = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_issue  = 0; ld_rd  = 0; done = 0; dcache_out = 0;
    rst = 1'b1;
    exp_q.delete();
    aq.delete();
    pend      = 1'b0;
    prd       = '0;
    conflicts = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wb_enable", wb_enable, 0);
    check("rst_wb_rd_addr", wb_rd_addr, 0);
    check("rst_wb_rd_data", wb_rd_data, 0);
    check("rst_stall", stall, 0);
    rst = 1'b0;
  endtask

  initial begin
    bit          hold, av, li, dn;
    logic [4:0]  hrd, ard, lrd;
    hold = 1'b0;
    hrd  = '0;

    fork
      forever begin
        @(negedge clk);
        if (!rst && wb_enable) begin
          if (exp_q.size() == 0) check("spurious_wb", wb_enable, 0);
          else check("wb_write", {wb_rd_addr, wb_rd_data}, exp_q.pop_front());
        end
      end
    join_none

    do_reset();

    // ALU only
    cycle(1, 5'd5, 32'h10000, 0, 0, 0, 0);
    idle(2);

    // Single load with three-cycle latency
    cycle(0, 0, 0, 1, 5'd3, 0, 0);
    idle(2);
    cycle(0, 0, 0, 0, 0, 1, 32'h101);
    idle(2);

    // Load return collides with an ALU result
    cycle(0, 0, 0, 1, 5'd3, 0, 0);
    idle(1);
    cycle(1, 5'd7, 32'h55, 0, 0, 1, 32'h101);
    idle(3);

    // Back-to-back loads fill the queue; a held issue while waiting must stall
    cycle(0, 0, 0, 1, 5'd9, 0, 0);
    cycle(0, 0, 0, 1, 5'd10, 0, 0);
    cycle(1, 5'd1, 32'h11, 1, 5'd10, 1, 32'h909);
    cycle(1, 5'd2, 32'h22, 0, 0, 1, 32'hA0A);
    cycle(0, 0, 0, 0, 0, 0, 0);
    idle(3);

    // rd 0 on both sources, then done while idle
    cycle(1, 5'd0, 32'hDEAD, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 5'd0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 32'hBEEF);
    cycle(0, 0, 0, 0, 0, 1, 32'hBEEF);
    idle(2);

    // Reset while a load is outstanding; the late done must be ignored
    cycle(0, 0, 0, 1, 5'd4, 0, 0);
    do_reset();
    cycle(0, 0, 0, 0, 0, 1, 32'h77);
    idle(2);

    for (int i = 0; i < 600; i++) begin
      dn = pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      if (hold) begin
        li  = 1'b1;
        lrd = hrd;
      end else begin
        li  = ($urandom_range(0, 3) == 0);
        lrd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      end
      av  = (aq.size() < QDEPTH) && ($urandom_range(0, 1) == 1);
      ard = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      cycle(av, ard, $urandom(), li, lrd, dn, $urandom());
      hold = li && !last_acc;
      hrd  = lrd;
    end

    // Finish any outstanding load, then drain with a bounded budget
    if (pend) cycle(0, 0, 0, 0, 0, 1, 32'h5A5A);
    for (int k = 0; k < 20 && (exp_q.size() > 0 || aq.size() > 0); k++) idle(1);
    idle(1);
    check("drain_empty", exp_q.size(), 0);
`ifdef WB_PERF_EN
    check("perf_conflicts", perf_conflicts, conflicts);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
